// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state multicycle MIPS-subset control FSM with decoded fields latched at ID exit.
module multicycle_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       rf_we,
  output logic       dm_re,
  output logic       dm_we,
  output logic [1:0] mem_width,
  output logic       load_unsigned,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic       reg_dst,
  output logic [1:0] reg_src,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       illegal
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
  typedef enum logic [2:0] {C_R, C_IMM, C_LD, C_ST, C_BEQ, C_J} cls_t;
  typedef struct packed {
    cls_t       cls;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       reg_dst;
    logic [1:0] reg_src;
    logic [1:0] mem_width;
    logic       load_unsigned;
  } ctl_t;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_NOR = 4'd4,
                         A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;
  state_t cur, nxt;
  ctl_t dec, ctl;
  logic ok, act;
  logic [3:0] cnt;
  logic [1:0] mw;
  logic pc_we_c, ir_we_c, rf_we_c, dm_re_c, dm_we_c, illegal_c;
  logic [1:0] pc_src_c;
  // lw/sw have bit1 set, halves bit0, bytes neither; bit2 marks the unsigned loads
  assign mw = opcode[1] ? 2'd0 : opcode[0] ? 2'd1 : 2'd2;
  always_comb begin
    dec = '0;
    ok = 1'b1;
    case (opcode)
      6'h00: begin
        dec.reg_dst = 1'b1;
        case (funct)
          6'h00: begin dec.alu_op = A_SLL; dec.alu_src_a = 1'b1; end
          6'h02: begin dec.alu_op = A_SRL; dec.alu_src_a = 1'b1; end
          6'h03: begin dec.alu_op = A_SRA; dec.alu_src_a = 1'b1; end
          6'h04: dec.alu_op = A_SLL;
          6'h06: dec.alu_op = A_SRL;
          6'h07: dec.alu_op = A_SRA;
          6'h20, 6'h21: dec.alu_op = A_ADD;
          6'h22, 6'h23: dec.alu_op = A_SUB;
          6'h24: dec.alu_op = A_AND;
          6'h25: dec.alu_op = A_OR;
          6'h27: dec.alu_op = A_NOR;
          6'h2a: dec.alu_op = A_SLT;
          6'h2b: dec.alu_op = A_SLTU;
          default: ok = 1'b0;
        endcase
      end
      6'h08: begin dec.cls = C_IMM; dec.alu_src_b = 2'd2; dec.ext_op = 1'b1; end
      6'h0d: begin dec.cls = C_IMM; dec.alu_src_b = 2'd2; dec.alu_op = A_OR; end
      6'h0f: begin dec.cls = C_IMM; dec.alu_src_b = 2'd2; dec.reg_src = 2'd2; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.cls = C_LD;
        dec.alu_src_b = 2'd2;
        dec.ext_op = 1'b1;
        dec.reg_src = 2'd1;
        dec.mem_width = mw;
        dec.load_unsigned = opcode[2];
      end
      6'h28, 6'h29, 6'h2b: begin
        dec.cls = C_ST;
        dec.alu_src_b = 2'd2;
        dec.ext_op = 1'b1;
        dec.mem_width = mw;
      end
      6'h04: begin dec.cls = C_BEQ; dec.alu_op = A_SUB; dec.ext_op = 1'b1; end
      6'h02: dec.cls = C_J;
      default: ok = 1'b0;
    endcase
  end
  always_comb begin
    nxt = S_IF;
    pc_we_c = 1'b0;
    ir_we_c = 1'b0;
    rf_we_c = 1'b0;
    dm_re_c = 1'b0;
    dm_we_c = 1'b0;
    illegal_c = 1'b0;
    pc_src_c = 2'd0;
    case (cur)
      S_IF: begin
        ir_we_c = 1'b1;
        pc_we_c = 1'b1;
        nxt = S_ID;
      end
      S_ID: begin
        illegal_c = !ok;
        nxt = ok ? S_EX : S_IF;
      end
      S_EX: begin
        pc_src_c = ctl.cls == C_BEQ ? 2'd1 : ctl.cls == C_J ? 2'd2 : 2'd0;
        pc_we_c = ctl.cls == C_J || (ctl.cls == C_BEQ && zero);
        nxt = (ctl.cls == C_BEQ || ctl.cls == C_J) ? S_IF :
              (ctl.cls == C_LD || ctl.cls == C_ST) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dm_re_c = ctl.cls == C_LD;
        dm_we_c = ctl.cls == C_ST;
        nxt = cnt > 4'd1 ? S_MEM : ctl.cls == C_LD ? S_WB : S_IF;
      end
      S_WB: rf_we_c = 1'b1;
      default: nxt = S_IF;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur <= S_IF;
      cnt <= '0;
      ctl <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_ID && ok) ctl <= dec;
      cnt <= (cur == S_EX && nxt == S_MEM) ? 4'(MEM_LAT) : cur == S_MEM ? cnt - 4'd1 : cnt;
    end
  end
  // outputs are gated by rst so reset clears them without waiting for a clock
  assign act = cur == S_EX || cur == S_MEM || cur == S_WB;
  assign {pc_we, ir_we, rf_we, dm_re, dm_we, illegal, pc_src} =
    rst ? {pc_we_c, ir_we_c, rf_we_c, dm_re_c, dm_we_c, illegal_c, pc_src_c} : '0;
  assign mem_width = rst && act ? ctl.mem_width : 2'd0;
  assign load_unsigned = rst && act && ctl.load_unsigned;
  assign alu_src_a = rst && act && ctl.alu_src_a;
  assign alu_src_b = !rst ? 2'd0 : act ? ctl.alu_src_b : cur == S_IF ? 2'd1 : 2'd0;
  assign alu_op = rst && act ? ctl.alu_op : 4'd0;
  assign ext_op = rst && act && ctl.ext_op;
  assign reg_dst = rst && act && ctl.reg_dst;
  assign reg_src = rst && act ? ctl.reg_src : 2'd0;
  assign state = cur;
endmodule
